jt900h_biu: RTL

Parametrised bus interface unit for the TLCS-900H core. It merges instruction prefetch and operand data access onto the single external RAM port. Prefetched bytes are buffered in a byte FIFO of configurable depth, and the bus data width is also configurable. The block sits between the control/PC logic and external RAM, replacing the fixed single-buffer memory controller. Operand accesses take priority over prefetch, and a PC write flushes the queue.

---
 rtl/jt900h_biu.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/jt900h_biu.sv
// TLCS-900H bus interface unit: prefetch byte queue plus operand access,
// sharing one external RAM port. Operand accesses win over prefetch in IDLE.
module jt900h_biu #(
  parameter int DW     = 16,
  parameter int QDEPTH = 8,
  parameter int AW     = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic                      pc_we,
  input  logic [AW-1:0]             pc_in,
  input  logic [2:0]                pop,
  output logic [31:0]               op,
  output logic [$clog2(QDEPTH):0]   q_cnt,
  output logic                      q_err,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [2:0]                d_len,
  input  logic [AW-1:0]             d_addr,
  input  logic [31:0]               d_wdata,
  output logic [31:0]               d_rdata,
  output logic                      d_ack,
  output logic [AW-1:0]             ram_addr,
  input  logic [DW-1:0]             ram_dout,
  output logic [DW-1:0]             ram_din,
  output logic [DW/8-1:0]           ram_we
);
  localparam int NB = DW / 8;
  localparam int QW = $clog2(QDEPTH);
  localparam int CW = QW + 1;
  localparam logic [AW-1:0] ALIGN = ~AW'(NB - 1);

  typedef enum logic [2:0] {IDLE, PF_ISSUE, PF_CAP, D_ISSUE, D_CAP, D_NEXT} state_t;
  state_t state_reg, state_next;

  logic [7:0]    q_mem [QDEPTH];
  logic [QW-1:0] head_reg, tail, tail1;
  logic [CW-1:0] cnt_reg, free_now, pop_ext;
  logic [AW-1:0] fa_reg, bus_addr_reg, start_fa;
  logic          q_err_reg, pf_kill_reg, wr_reg;
  logic [2:0]    len_reg, len_eff;
  logic [3:0]    off_reg, pos_reg, span_end;
  logic [31:0]   wdata_reg, rd_acc_reg, d_rdata_reg, rd_merge;
  logic [1:0]    pf_yield, start_yield;
  logic [15:0]   dout16;
  logic          pop_ok, pop_err, push, more;
  logic [NB-1:0] lane_act;
  logic [1:0]    lane_idx [NB];

  // A flush in IDLE redirects the fetch decision to pc_in with an empty queue
  assign start_fa    = pc_we ? pc_in : fa_reg;
  assign pf_yield    = (NB == 2 && !fa_reg[0])   ? 2'd2 : 2'd1;
  assign start_yield = (NB == 2 && !start_fa[0]) ? 2'd2 : 2'd1;
  assign free_now    = pc_we ? CW'(QDEPTH) : CW'(QDEPTH) - cnt_reg;
  assign pop_ext     = CW'(pop);
  assign pop_ok      = (pop != 3'd0) && (pop_ext <= cnt_reg);
  assign pop_err     = pop_ext > cnt_reg;
  assign push        = (state_reg == PF_CAP) && !pf_kill_reg;
  assign tail        = head_reg + cnt_reg[QW-1:0];
  assign tail1       = tail + QW'(1);
  assign dout16      = 16'(ram_dout);

  assign len_eff  = (d_len == 3'd1 || d_len == 3'd2 || d_len == 3'd4) ? d_len : 3'd4;
  assign span_end = off_reg + {1'b0, len_reg};
  assign more     = (pos_reg + 4'(NB)) < span_end;

  genvar gi;
  // Access bytes are numbered from the aligned start; lane gi holds byte pos+gi
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [3:0] p;
      assign p            = pos_reg + 4'(gi);
      assign lane_act[gi] = (p >= off_reg) && (p < span_end);
      assign lane_idx[gi] = 2'(p - off_reg);
      assign ram_din[8*gi +: 8] = wdata_reg[{lane_idx[gi], 3'b000} +: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_op
      assign op[8*gi +: 8] = q_mem[head_reg + QW'(gi)];
    end
  endgenerate

  always_comb begin
    rd_merge = rd_acc_reg;
    for (int i = 0; i < NB; i++)
      if (lane_act[i]) rd_merge[{lane_idx[i], 3'b000} +: 8] = ram_dout[8*i +: 8];
  end

  assign ram_addr = bus_addr_reg;
  assign ram_we   = (state_reg == D_ISSUE && wr_reg) ? lane_act : '0;
  assign d_ack    = (state_reg == D_CAP || state_reg == D_NEXT) && !more;
  assign d_rdata  = (state_reg == D_CAP && !more) ? rd_merge : d_rdata_reg;
  assign q_cnt    = cnt_reg;
  assign q_err    = q_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else if (cen) state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (d_req) state_next = D_ISSUE;
        else if (free_now >= CW'(start_yield)) state_next = PF_ISSUE;
      end
      PF_ISSUE: state_next = PF_CAP;
      PF_CAP:   state_next = IDLE;
      D_ISSUE:  state_next = wr_reg ? D_NEXT : D_CAP;
      D_CAP, D_NEXT: state_next = more ? D_ISSUE : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Prefetch queue; a flush overrides both push and pop of the same tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      cnt_reg   <= '0;
      fa_reg    <= '0;
      q_err_reg <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) q_mem[i] <= 8'h00;
    end else if (cen) begin
      q_err_reg <= 1'b0;
      if (pc_we) begin
        head_reg <= '0;
        cnt_reg  <= '0;
        fa_reg   <= pc_in;
      end else begin
        if (push) begin
          if (pf_yield == 2'd2) begin
            q_mem[tail]  <= dout16[7:0];
            q_mem[tail1] <= dout16[15:8];
          end else begin
            q_mem[tail] <= (NB == 2) ? dout16[15:8] : dout16[7:0];
          end
          fa_reg <= fa_reg + AW'(pf_yield);
        end
        if (pop_ok) head_reg <= head_reg + pop_ext[QW-1:0];
        q_err_reg <= pop_err;
        cnt_reg   <= cnt_reg + (push ? CW'(pf_yield) : '0) - (pop_ok ? pop_ext : '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_addr_reg <= '0;
      pf_kill_reg  <= 1'b0;
      wr_reg       <= 1'b0;
      len_reg      <= '0;
      off_reg      <= '0;
      pos_reg      <= '0;
      wdata_reg    <= '0;
      rd_acc_reg   <= '0;
      d_rdata_reg  <= '0;
    end else if (cen) begin
      if ((state_reg == PF_ISSUE || state_reg == PF_CAP) && pc_we) pf_kill_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (d_req) begin
            bus_addr_reg <= d_addr & ALIGN;
            wr_reg       <= d_we;
            len_reg      <= len_eff;
            off_reg      <= (NB == 2) ? {3'b000, d_addr[0]} : 4'd0;
            pos_reg      <= '0;
            wdata_reg    <= d_wdata;
            rd_acc_reg   <= '0;
          end else if (state_next == PF_ISSUE) begin
            bus_addr_reg <= start_fa & ALIGN;
            pf_kill_reg  <= 1'b0;
          end
        end
        D_CAP, D_NEXT: begin
          if (more) begin
            pos_reg      <= pos_reg + 4'(NB);
            bus_addr_reg <= bus_addr_reg + AW'(NB);
          end
        end
        default: ;
      endcase
      if (state_reg == D_CAP) begin
        rd_acc_reg <= rd_merge;
        if (!more) d_rdata_reg <= rd_merge;
      end
    end
  end
endmodule
